// File: rtl/video_in_pkg.sv
// Shared definitions for the video input path (video_in_pack and video_in_store):
// frame geometry, burst size, FIFO depth and the capture FSM state type.
package video_in_pkg;

   localparam int p_WIDTH    = 640;
   localparam int p_HEIGHT   = 480;
   localparam int NB_PACK    = 16;
   localparam int FIFO_DEPTH = 64;
   localparam int PIX_CNT_W  = 19;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ARM      = 3'd1,
      S_WAIT_SOF = 3'd2,
      S_CAPTURE  = 3'd3,
      S_DONE     = 3'd4
   } video_in_state_e;

endpackage

// File: rtl/video_in_fifo.sv
// First-word-fall-through synchronous FIFO with flush, drop flag on a full push
// and a registered "at least LEVEL words buffered" flag.
module video_in_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 64,
   parameter int LEVEL = 16
) (
   input  logic             clk,
   input  logic             nRST,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             at_level,
   output logic             dropped
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
   localparam logic [CW-1:0] LEVEL_C = CW'(LEVEL);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_next;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_C);
   assign do_pop  = pop && (count != '0);
   // A pop in the same cycle frees the slot, so a push on a full FIFO is still accepted.
   assign do_push = push && (!full || do_pop);
   assign dropped = push && full && !do_pop;

   always_comb begin
      count_next = count;
      if (flush)
         count_next = '0;
      else if (do_push && !do_pop)
         count_next = count + 1'b1;
      else if (do_pop && !do_push)
         count_next = count - 1'b1;
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         at_level <= 1'b0;
      end else begin
         count    <= count_next;
         at_level <= (count_next >= LEVEL_C);
         if (flush) begin
            wptr <= '0;
            rptr <= '0;
         end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush)
         mem[wptr] <= din;
   end

   assign dout = (count != '0) ? mem[rptr] : '0;

endmodule

// File: rtl/video_in_pack.sv
// Camera front end: captures one frame per new_addr, packs 4 luma pixels per
// little-endian 32-bit word and buffers the words for video_in_store.
module video_in_pack
   import video_in_pkg::*;
#(
   // Frame geometry is overridable so short frames can be exercised quickly.
   parameter int WIDTH_PX  = p_WIDTH,
   parameter int HEIGHT_PX = p_HEIGHT
) (
   input  logic            clk,
   input  logic            nRST,
   input  logic [7:0]      pixel_in,
   input  logic            frame_valid,
   input  logic            line_valid,
   input  logic            new_addr,
   input  logic            r_ack,
   output logic [31:0]     data_fifo,
   output logic            nb_pack_available,
   output logic            overflow,
   output logic            frame_err,
   output video_in_state_e dbg_state
);

   localparam logic [PIX_CNT_W-1:0] LAST_PIX = PIX_CNT_W'(WIDTH_PX * HEIGHT_PX - 1);

   video_in_state_e      state;
   logic [31:0]          pack_q;
   logic [1:0]           byte_idx;
   logic                 push_q;
   logic [PIX_CNT_W-1:0] pix_cnt;
   logic                 capture;
   logic                 fifo_dropped;

   // The cycle that leaves WAIT_SOF may already carry the first pixel.
   assign capture = frame_valid && line_valid &&
                    ((state == S_CAPTURE) || (state == S_WAIT_SOF));

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state     <= S_IDLE;
         pack_q    <= '0;
         byte_idx  <= '0;
         push_q    <= 1'b0;
         pix_cnt   <= '0;
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else if (new_addr) begin
         state     <= S_ARM;
         pack_q    <= '0;
         byte_idx  <= '0;
         push_q    <= 1'b0;
         pix_cnt   <= '0;
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         push_q <= capture && (byte_idx == 2'd3);
         if (fifo_dropped)
            overflow <= 1'b1;
         if (capture) begin
            pack_q[{byte_idx, 3'b000} +: 8] <= pixel_in;
            byte_idx <= byte_idx + 1'b1;
            pix_cnt  <= pix_cnt + 1'b1;
         end
         case (state)
            S_ARM:      if (!frame_valid) state <= S_WAIT_SOF;
            S_WAIT_SOF: if (frame_valid)  state <= S_CAPTURE;
            S_CAPTURE: begin
               if (!frame_valid) begin
                  state     <= S_IDLE;
                  frame_err <= 1'b1;
               end else if (capture && (pix_cnt == LAST_PIX)) begin
                  state <= S_DONE;
               end
            end
            default: ;
         endcase
      end
   end

   assign dbg_state = state;

   video_in_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH),
      .LEVEL (NB_PACK)
   ) u_fifo (
      .clk      (clk),
      .nRST     (nRST),
      .flush    (new_addr),
      .push     (push_q),
      .pop      (r_ack),
      .din      (pack_q),
      .dout     (data_fifo),
      .at_level (nb_pack_available),
      .dropped  (fifo_dropped)
   );

endmodule

// File: tb/tb_video_in_pack.sv
// Bench for video_in_pack on a 40x32 frame: directed frames, a burst-popping
// monitor that checks every popped word against an expected queue.
module tb_video_in_pack;
   import video_in_pkg::*;

   localparam int W     = 40;
   localparam int H     = 32;
   localparam int TOTAL = W * H;

   logic            clk = 1'b0;
   logic            nRST;
   logic [7:0]      pixel_in;
   logic            frame_valid;
   logic            line_valid;
   logic            new_addr;
   logic            ack_stim;
   logic            ack_mon;
   logic            r_ack;
   logic [31:0]     data_fifo;
   logic            nb_pack_available;
   logic            overflow;
   logic            frame_err;
   video_in_state_e dbg_state;

   assign r_ack = ack_stim | ack_mon;

   video_in_pack #(.WIDTH_PX(W), .HEIGHT_PX(H)) dut (
      .clk               (clk),
      .nRST              (nRST),
      .pixel_in          (pixel_in),
      .frame_valid       (frame_valid),
      .line_valid        (line_valid),
      .new_addr          (new_addr),
      .r_ack             (r_ack),
      .data_fifo         (data_fifo),
      .nb_pack_available (nb_pack_available),
      .overflow          (overflow),
      .frame_err         (frame_err),
      .dbg_state         (dbg_state)
   );

   always #5 clk = ~clk;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] exp_q[$];
   int          burst_left  = 0;
   int          drain_left  = 0;
   int          cool        = 0;
   bit          auto_pop    = 1'b0;
   logic [31:0] model_word  = '0;
   int          model_k     = 0;
   bit          model_drop  = 1'b0;
   int          line_pos    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- monitor: pops bursts / drains and scores each word
   task automatic pop_one();
      if (exp_q.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL pop_extra: got %h, expected no word", data_fifo);
      end else begin
         check("pop_data", data_fifo, exp_q.pop_front());
      end
      ack_mon = 1'b1;
   endtask

   initial begin
      ack_mon = 1'b0;
      forever begin
         @(negedge clk);
         ack_mon = 1'b0;
         if (!nRST) begin
            burst_left = 0;
            cool       = 0;
         end else begin
            if (cool > 0)
               cool--;
            else if (burst_left == 0 && drain_left == 0 && auto_pop && nb_pack_available)
               burst_left = NB_PACK;
            if (burst_left > 0) begin
               pop_one();
               burst_left--;
               if (burst_left == 0) cool = 2;
            end else if (drain_left > 0) begin
               pop_one();
               drain_left--;
            end
         end
      end
   end

   // ---------------- driver tasks
   task automatic pulse_new_addr(input bit with_ack);
      @(negedge clk);
      new_addr   = 1'b1;
      ack_stim   = with_ack;
      exp_q.delete();
      model_k    = 0;
      model_word = '0;
      @(negedge clk);
      new_addr   = 1'b0;
      ack_stim   = 1'b0;
   endtask

   task automatic start_frame();
      @(negedge clk);
      frame_valid = 1'b0;
      line_valid  = 1'b0;
      @(negedge clk);
      line_pos = 0;
   endtask

   task automatic end_frame();
      @(negedge clk);
      frame_valid = 1'b0;
      line_valid  = 1'b0;
   endtask

   task automatic line_pause(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         line_valid = 1'b0;
      end
   endtask

   task automatic send_pixels(input int n, input int start, input bit expect_cap);
      for (int i = 0; i < n; i++) begin
         if (line_pos == W) begin
            @(negedge clk);
            line_valid = 1'b0;
            line_pos   = 0;
         end
         @(negedge clk);
         frame_valid = 1'b1;
         line_valid  = 1'b1;
         pixel_in    = 8'(start + i);
         line_pos++;
         if (expect_cap) begin
            model_word[8*model_k +: 8] = pixel_in;
            model_k++;
            if (model_k == 4) begin
               model_k = 0;
               if (!model_drop) exp_q.push_back(model_word);
            end
         end
      end
   endtask

   task automatic drain_all(input string name);
      int t = 0;
      while ((burst_left != 0 || cool != 0 || (auto_pop && nb_pack_available)) && t < 4000) begin
         @(negedge clk);
         t++;
      end
      drain_left = exp_q.size();
      while (drain_left != 0 && t < 4000) begin
         @(negedge clk);
         t++;
      end
      repeat (2) @(negedge clk);
      if (t >= 4000) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_timeout: got %0d words left, expected 0", name, exp_q.size());
      end
      check({name, "_empty"}, data_fifo, 32'h0);
   endtask

   // ---------------- directed sequence
   initial begin
      nRST = 1'b0; pixel_in = '0; frame_valid = 1'b0; line_valid = 1'b0;
      new_addr = 1'b0; ack_stim = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_data", data_fifo, 32'h0);
      check("rst_nb", 32'(nb_pack_available), 32'h0);
      check("rst_ovf", 32'(overflow), 32'h0);
      check("rst_ferr", 32'(frame_err), 32'h0);
      check("rst_state", 32'(dbg_state), 32'(S_IDLE));
      nRST = 1'b1;

      // frame with ramp pixels, burst threshold timing, then full frame drained
      pulse_new_addr(1'b0);
      check("arm_state", 32'(dbg_state), 32'(S_ARM));
      start_frame();
      check("wait_sof_state", 32'(dbg_state), 32'(S_WAIT_SOF));
      send_pixels(64, 0, 1'b1);
      @(negedge clk); line_valid = 1'b0;
      check("nb_before_16th_push", 32'(nb_pack_available), 32'h0);
      @(negedge clk);
      check("nb_after_16th_push", 32'(nb_pack_available), 32'h1);
      check("first_word", data_fifo, 32'h03020100);
      check("capture_state", 32'(dbg_state), 32'(S_CAPTURE));
      auto_pop = 1'b1;
      send_pixels(TOTAL - 64, 64, 1'b1);
      line_pause(2);
      check("done_state", 32'(dbg_state), 32'(S_DONE));
      start_frame();
      send_pixels(100, 8'hA0, 1'b0);
      end_frame();
      repeat (2) @(negedge clk);
      check("done_ignores_frame", 32'(dbg_state), 32'(S_DONE));
      check("done_no_ferr", 32'(frame_err), 32'h0);
      drain_all("full_frame");
      check("full_frame_ovf", 32'(overflow), 32'h0);
      check("full_frame_nb", 32'(nb_pack_available), 32'h0);

      // overflow on the 65th word, then push+pop while full
      auto_pop = 1'b0;
      pulse_new_addr(1'b0);
      start_frame();
      send_pixels(256, 0, 1'b1);
      line_pause(2);
      check("full_no_ovf", 32'(overflow), 32'h0);
      check("full_nb", 32'(nb_pack_available), 32'h1);
      model_drop = 1'b1;
      send_pixels(4, 256, 1'b1);
      model_drop = 1'b0;
      @(negedge clk); line_valid = 1'b0;
      check("ovf_before_65th", 32'(overflow), 32'h0);
      @(negedge clk);
      check("ovf_on_65th", 32'(overflow), 32'h1);
      send_pixels(4, 1000, 1'b1);
      @(negedge clk); line_valid = 1'b0;
      check("full_pop_head", data_fifo, exp_q[0]);
      void'(exp_q.pop_front());
      ack_stim = 1'b1;
      @(negedge clk); ack_stim = 1'b0;
      check("pushpop_ovf_kept", 32'(overflow), 32'h1);
      check("pushpop_nb", 32'(nb_pack_available), 32'h1);
      end_frame();
      repeat (2) @(negedge clk);
      check("early_end_ferr", 32'(frame_err), 32'h1);
      check("early_end_idle", 32'(dbg_state), 32'(S_IDLE));
      drain_all("overflow");

      // new_addr during an active frame, then new_addr together with r_ack
      @(negedge clk); frame_valid = 1'b1; line_valid = 1'b1; pixel_in = 8'h55; line_pos = 0;
      repeat (3) @(negedge clk);
      pulse_new_addr(1'b0);
      send_pixels(20, 8'h55, 1'b0);
      check("arm_mid_frame", 32'(dbg_state), 32'(S_ARM));
      check("arm_mid_frame_data", data_fifo, 32'h0);
      start_frame();
      send_pixels(64, 16, 1'b1);
      line_pause(2);
      check("second_capture_head", data_fifo, 32'h13121110);
      check("second_capture_nb", 32'(nb_pack_available), 32'h1);
      pulse_new_addr(1'b1);
      check("flush_ack_data", data_fifo, 32'h0);
      check("flush_ack_nb", 32'(nb_pack_available), 32'h0);
      check("flush_ack_state", 32'(dbg_state), 32'(S_ARM));

      // frame_valid falls after 1000 pixels: 250 words delivered
      auto_pop = 1'b1;
      start_frame();
      send_pixels(1000, 7, 1'b1);
      end_frame();
      repeat (2) @(negedge clk);
      check("short_frame_ferr", 32'(frame_err), 32'h1);
      check("short_frame_idle", 32'(dbg_state), 32'(S_IDLE));
      check("short_frame_ovf", 32'(overflow), 32'h0);
      drain_all("short_frame");
      auto_pop = 1'b0;
      pulse_new_addr(1'b0);
      check("ferr_cleared", 32'(frame_err), 32'h0);
      check("ferr_cleared_state", 32'(dbg_state), 32'(S_ARM));

      // asynchronous reset in the middle of a capture
      start_frame();
      send_pixels(30, 3, 1'b1);
      #2 nRST = 1'b0;
      #1;
      check("midrst_data", data_fifo, 32'h0);
      check("midrst_state", 32'(dbg_state), 32'(S_IDLE));
      check("midrst_nb", 32'(nb_pack_available), 32'h0);
      check("midrst_ferr", 32'(frame_err), 32'h0);
      check("midrst_ovf", 32'(overflow), 32'h0);
      exp_q.delete();
      model_k = 0;
      @(negedge clk); nRST = 1'b1;
      pulse_new_addr(1'b0);
      auto_pop = 1'b1;
      start_frame();
      send_pixels(TOTAL, 200, 1'b1);
      line_pause(2);
      check("post_rst_done", 32'(dbg_state), 32'(S_DONE));
      end_frame();
      drain_all("post_rst_frame");
      check("post_rst_ovf", 32'(overflow), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of sequence, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
